// File: rtl/rv32i_decode_exec.sv
// Registered decode/execute stage for the multi-cycle RV32I core: control decode,
// immediate extension, ALU and next-PC, all captured on in_valid. Only XLEN = 32 is supported.
module rv32i_decode_exec #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc_next,
  output logic [2:0]      result_src,
  output logic            alu_src,
  output logic            reg_wen,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic            illegal
);

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluEq   = 4'd10,
    AluNe   = 4'd11,
    AluGe   = 4'd12,
    AluGeu  = 4'd13,
    AluNone = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       f7b5;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];

  // Register-register and immediate arithmetic share one funct3 map; only OP uses f7b5 for SUB.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    alu_op_e res;
    case (f3)
      3'b000:  res = (is_reg && alt) ? AluSub : AluAdd;
      3'b001:  res = AluSll;
      3'b010:  res = AluSlt;
      3'b011:  res = AluSltu;
      3'b100:  res = AluXor;
      3'b101:  res = alt ? AluSra : AluSrl;
      3'b110:  res = AluOr;
      default: res = AluAnd;
    endcase
    return res;
  endfunction

  logic [2:0] result_src_d;
  logic       alu_src_d;
  logic       reg_wen_d;
  logic       mem_wen_d;
  logic       illegal_d;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;
  imm_fmt_e   imm_fmt;
  alu_op_e    alu_op;

  always_comb begin
    result_src_d = 3'd0;
    alu_src_d    = 1'b0;
    reg_wen_d    = 1'b0;
    mem_wen_d    = 1'b0;
    illegal_d    = 1'b0;
    is_branch    = 1'b0;
    is_jal       = 1'b0;
    is_jalr      = 1'b0;
    imm_fmt      = ImmNone;
    alu_op       = AluAdd;
    case (op)
      OpReg: begin
        reg_wen_d = 1'b1;
        alu_op    = alu_from_f3(funct3, f7b5, 1'b1);
      end
      OpImm: begin
        alu_src_d = 1'b1;
        reg_wen_d = 1'b1;
        imm_fmt   = ImmI;
        alu_op    = alu_from_f3(funct3, f7b5, 1'b0);
      end
      OpLoad: begin
        result_src_d = 3'd4;
        alu_src_d    = 1'b1;
        reg_wen_d    = 1'b1;
        imm_fmt      = ImmI;
      end
      OpStore: begin
        alu_src_d = 1'b1;
        mem_wen_d = 1'b1;
        imm_fmt   = ImmS;
      end
      OpBranch: begin
        is_branch = 1'b1;
        imm_fmt   = ImmB;
        case (funct3)
          3'b000:  alu_op = AluEq;
          3'b001:  alu_op = AluNe;
          3'b100:  alu_op = AluSlt;
          3'b101:  alu_op = AluGe;
          3'b110:  alu_op = AluSltu;
          3'b111:  alu_op = AluGeu;
          default: begin
            // Result forced to 0 so an illegal branch falls through to pc+4.
            alu_op    = AluNone;
            illegal_d = 1'b1;
          end
        endcase
      end
      OpLui: begin
        result_src_d = 3'd1;
        alu_src_d    = 1'b1;
        reg_wen_d    = 1'b1;
        imm_fmt      = ImmU;
      end
      OpAuipc: begin
        result_src_d = 3'd2;
        alu_src_d    = 1'b1;
        reg_wen_d    = 1'b1;
        imm_fmt      = ImmU;
      end
      OpJal: begin
        result_src_d = 3'd3;
        alu_src_d    = 1'b1;
        reg_wen_d    = 1'b1;
        imm_fmt      = ImmJ;
        is_jal       = 1'b1;
      end
      OpJalr: begin
        result_src_d = 3'd3;
        alu_src_d    = 1'b1;
        reg_wen_d    = 1'b1;
        imm_fmt      = ImmI;
        is_jalr      = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic [31:0] imm_d;

  always_comb begin
    imm_d = 32'd0;
    case (imm_fmt)
      ImmI:    imm_d = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm_d = {instr[31:12], 12'b0};
      ImmJ:    imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_d = 32'd0;
    endcase
  end

  logic [31:0] in2;
  logic [31:0] alu_d;
  logic [4:0]  shamt;

  assign in2   = alu_src_d ? imm_d : rs2;
  assign shamt = in2[4:0];

  always_comb begin
    alu_d = 32'd0;
    case (alu_op)
      AluAdd:  alu_d = rs1 + in2;
      AluSub:  alu_d = rs1 - in2;
      AluSll:  alu_d = rs1 << shamt;
      AluSlt:  alu_d = {31'd0, $signed(rs1) < $signed(in2)};
      AluSltu: alu_d = {31'd0, rs1 < in2};
      AluXor:  alu_d = rs1 ^ in2;
      AluSrl:  alu_d = rs1 >> shamt;
      AluSra:  alu_d = $unsigned($signed(rs1) >>> shamt);
      AluOr:   alu_d = rs1 | in2;
      AluAnd:  alu_d = rs1 & in2;
      AluEq:   alu_d = {31'd0, rs1 == in2};
      AluNe:   alu_d = {31'd0, rs1 != in2};
      AluGe:   alu_d = {31'd0, $signed(rs1) >= $signed(in2)};
      AluGeu:  alu_d = {31'd0, rs1 >= in2};
      default: alu_d = 32'd0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] addr_d;
  logic [31:0] pc_next_d;

  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm_d;
  assign addr_d      = rs1 + imm_d;

  always_comb begin
    pc_next_d = pc_plus4;
    if (is_branch && alu_d[0]) begin
      pc_next_d = pc_plus_imm;
    end else if (is_jal) begin
      pc_next_d = pc_plus_imm;
    end else if (is_jalr) begin
      pc_next_d = {addr_d[31:1], 1'b0};
    end
  end

  logic        out_valid_q;
  logic [31:0] alu_result_q;
  logic [31:0] imm_ext_q;
  logic [31:0] pc_next_q;
  logic [2:0]  result_src_q;
  logic        alu_src_q;
  logic        reg_wen_q;
  logic        mem_wen_q;
  logic [31:0] mem_addr_q;
  logic        illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      imm_ext_q    <= '0;
      pc_next_q    <= '0;
      result_src_q <= '0;
      alu_src_q    <= 1'b0;
      reg_wen_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        alu_result_q <= alu_d;
        imm_ext_q    <= imm_d;
        pc_next_q    <= pc_next_d;
        result_src_q <= result_src_d;
        alu_src_q    <= alu_src_d;
        reg_wen_q    <= reg_wen_d;
        mem_wen_q    <= mem_wen_d;
        mem_addr_q   <= addr_d;
        illegal_q    <= illegal_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign imm_ext    = imm_ext_q;
  assign pc_next    = pc_next_q;
  assign result_src = result_src_q;
  assign alu_src    = alu_src_q;
  assign reg_wen    = reg_wen_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Directed-vector bench for rv32i_decode_exec with hand-computed expectations.
module tb_rv32i_decode_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] imm_ext;
  logic [31:0] pc_next;
  logic [2:0]  result_src;
  logic        alu_src;
  logic        reg_wen;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic        illegal;

  int n_vec;
  int n_err;

  rv32i_decode_exec #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .instr      (instr),
    .rs1        (rs1),
    .rs2        (rs2),
    .pc         (pc),
    .out_valid  (out_valid),
    .alu_result (alu_result),
    .imm_ext    (imm_ext),
    .pc_next    (pc_next),
    .result_src (result_src),
    .alu_src    (alu_src),
    .reg_wen    (reg_wen),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i_instr, input logic [31:0] i_rs1,
                       input logic [31:0] i_rs2, input logic [31:0] i_pc);
    instr    = i_instr;
    rs1      = i_rs1;
    rs2      = i_rs2;
    pc       = i_pc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_valid"},  {31'd0, out_valid}, 32'd0);
    check({tag, ".alu_result"}, alu_result, 32'd0);
    check({tag, ".imm_ext"},    imm_ext, 32'd0);
    check({tag, ".pc_next"},    pc_next, 32'd0);
    check({tag, ".result_src"}, {29'd0, result_src}, 32'd0);
    check({tag, ".ctrl"},       {28'd0, alu_src, reg_wen, mem_wen, illegal}, 32'd0);
    check({tag, ".mem_addr"},   mem_addr, 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    instr    = $urandom;
    rs1      = $urandom;
    rs2      = $urandom;
    pc       = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset.out_valid", {31'd0, out_valid}, 32'd0);

    apply(32'h002081B3, 32'd5, 32'd7, 32'h0);
    check("add.out_valid",  {31'd0, out_valid}, 32'd1);
    check("add.alu",        alu_result, 32'd12);
    check("add.reg_wen",    {31'd0, reg_wen}, 32'd1);
    check("add.result_src", {29'd0, result_src}, 32'd0);
    check("add.imm",        imm_ext, 32'd0);

    apply(32'h402081B3, 32'd5, 32'd7, 32'h0);
    check("sub.alu", alu_result, 32'hFFFFFFFE);

    // Bit 30 set in the immediate must not turn ADDI into a subtract.
    apply(32'hFFF00093, 32'd0, 32'd123, 32'h0);
    check("addi.imm",     imm_ext, 32'hFFFFFFFF);
    check("addi.alu",     alu_result, 32'hFFFFFFFF);
    check("addi.alu_src", {31'd0, alu_src}, 32'd1);

    apply(32'h4040D093, 32'h80000000, 32'd0, 32'h0);
    check("srai.alu", alu_result, 32'hF8000000);

    apply(32'h00208463, 32'd3, 32'd3, 32'h100);
    check("beq_t.pc_next", pc_next, 32'h108);
    check("beq_t.reg_wen", {31'd0, reg_wen}, 32'd0);
    check("beq_t.imm",     imm_ext, 32'd8);
    check("beq_t.alu",     alu_result, 32'd1);

    apply(32'h00208463, 32'd3, 32'd4, 32'h100);
    check("beq_nt.pc_next", pc_next, 32'h104);
    check("beq_nt.alu",     alu_result, 32'd0);

    apply(32'h0020A463, 32'd3, 32'd3, 32'h100);
    check("br_f3_010.illegal", {31'd0, illegal}, 32'd1);
    check("br_f3_010.pc_next", pc_next, 32'h104);

    apply(32'h010000EF, 32'd0, 32'd0, 32'h20);
    check("jal.pc_next",    pc_next, 32'h30);
    check("jal.result_src", {29'd0, result_src}, 32'd3);
    check("jal.imm",        imm_ext, 32'd16);

    apply(32'h000280E7, 32'h1001, 32'd0, 32'h80);
    check("jalr.pc_next",    pc_next, 32'h1000);
    check("jalr.result_src", {29'd0, result_src}, 32'd3);

    apply(32'h123450B7, 32'd0, 32'd0, 32'h0);
    check("lui.imm",        imm_ext, 32'h12345000);
    check("lui.result_src", {29'd0, result_src}, 32'd1);
    check("lui.reg_wen",    {31'd0, reg_wen}, 32'd1);

    apply(32'h00001097, 32'd0, 32'd0, 32'h100);
    check("auipc.imm",        imm_ext, 32'h1000);
    check("auipc.result_src", {29'd0, result_src}, 32'd2);

    apply(32'h00812083, 32'h100, 32'd0, 32'h0);
    check("lw.result_src", {29'd0, result_src}, 32'd4);
    check("lw.mem_addr",   mem_addr, 32'h108);
    check("lw.mem_wen",    {31'd0, mem_wen}, 32'd0);

    apply(32'hFE20AE23, 32'h200, 32'hDEAD, 32'h0);
    check("sw.mem_addr", mem_addr, 32'h1FC);
    check("sw.mem_wen",  {31'd0, mem_wen}, 32'd1);
    check("sw.reg_wen",  {31'd0, reg_wen}, 32'd0);
    check("sw.imm",      imm_ext, 32'hFFFFFFFC);

    apply(32'h0000007F, 32'd1, 32'd2, 32'h40);
    check("illegal.flag",       {31'd0, illegal}, 32'd1);
    check("illegal.pc_next",    pc_next, 32'h44);
    check("illegal.reg_wen",    {31'd0, reg_wen}, 32'd0);
    check("illegal.result_src", {29'd0, result_src}, 32'd0);
    check("illegal.imm",        imm_ext, 32'd0);

    // New inputs with in_valid low must not disturb the captured values.
    in_valid = 1'b0;
    instr    = 32'h002081B3;
    rs1      = 32'd9;
    rs2      = 32'd9;
    pc       = 32'h500;
    @(posedge clk);
    #1;
    check("hold.out_valid", {31'd0, out_valid}, 32'd0);
    check("hold.pc_next",   pc_next, 32'h44);
    check("hold.illegal",   {31'd0, illegal}, 32'd1);
    check("hold.reg_wen",   {31'd0, reg_wen}, 32'd0);

    apply(32'h002081B3, 32'd1, 32'd2, 32'h0);
    check("pre_mid_reset.alu", alu_result, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset.out_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
